ram_rd_bypass: RTL and testbench
================================

# ram_rd_bypass

Read-side front end for the 1R1W synchronous SRAM (read-first, 1-cycle read latency) whose write-collision data is held by the delay register.
- Accepts read requests, issues them to the RAM, and detects a same-cycle write to the same address.
- On a collision it substitutes the write data for the stale RAM output.
- It delivers responses in order through a 3-entry valid/ready output buffer, with credit-based backpressure to the requester.

## Interface
Parameters:
- RAM_DATA_WIDTH, 272, data word width
- RAM_ADDR_WIDTH, 8, address width
- RAM_DEPTH, 256, number of RAM words (addresses ≥ RAM_DEPTH are not issued by users)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- wr_en  input  1  RAM write strobe (snooped, same signal driving the RAM)
- wr_addr  input  RAM_ADDR_WIDTH  RAM write address
- wr_data  input  RAM_DATA_WIDTH  RAM write data
- rd_req_valid  input  1  read request valid
- rd_req_ready  output  1  read request accepted when valid && ready
- rd_addr  input  RAM_ADDR_WIDTH  read request address
- ram_rd_en  output  1  RAM read enable
- ram_rd_addr  output  RAM_ADDR_WIDTH  RAM read address
- ram_rd_data  input  RAM_DATA_WIDTH  RAM read data, valid 1 cycle after ram_rd_en
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer ready
- rsp_data  output  RAM_DATA_WIDTH  response data

## Operation
- **Accept:** accept = rd_req_valid && rd_req_ready.
  - ram_rd_en = accept (combinational).
  - ram_rd_addr = rd_addr (combinational, passes through even when not accepted).
- **Credit rule:** rd_req_ready = (fifo_count + inflight) < 3.
  - fifo_count is the registered buffer occupancy, 0..3.
  - inflight is a registered flag: 1 if a request was accepted last cycle.
  - A same-cycle pop is not credited.
  - rd_req_ready and ram_rd_en are forced 0 while rst_n is low.
- **Collision capture (cycle T of accept):**
  - Register byp_hit = wr_en && (wr_addr == rd_addr).
  - Register byp_data = wr_data, loaded only when byp_hit; held otherwise.
- **Return (cycle T+1, inflight = 1):**
  - Push (byp_hit ? byp_data : ram_rd_data) into the FIFO.
  - A write at T+1 to the same address does not affect the returned value (the RAM already sampled at T).
- **FIFO:**
  - 3 entries, in order, with registered rd/wr pointers that wrap 2→0 and an occupancy counter.
  - pop = rsp_valid && rsp_ready.
  - A simultaneous push and pop leaves the count unchanged.
  - Push into a full FIFO cannot occur (guaranteed by the credit rule); assert this in simulation.
- **Outputs:**
  - rsp_valid = (fifo_count != 0).
  - rsp_data = head entry.
  - Once rsp_valid is high, rsp_data is held stable until popped.
- **Reset (async, also mid-operation):**
  - fifo_count, pointers, inflight, byp_hit clear to 0.
  - byp_data and FIFO storage clear to 0.
  - Any in-flight request and buffered responses are discarded; no response is issued for them.
  - Output values during/after reset: rsp_valid=0, rsp_data=0, rd_req_ready=0 during reset and 1 on the first cycle after release, ram_rd_en=0.

## Timing
- **Latency:** request accepted at edge-cycle T → RAM data at T+1 → rsp_valid at T+2 when the FIFO was empty. Minimum latency is 2 cycles.
- **Throughput:** with rsp_ready held high, one request per cycle is sustained indefinitely (steady state: count=1, inflight=1).
- **Backpressure:**
  - With rsp_ready low, at most 3 requests are accepted.
  - rd_req_ready drops once count + inflight reaches 3.
  - It reasserts in the cycle after the first pop.
- **Order:** responses are strictly in request order; collision and non-collision responses are interleaved correctly.
- **Collision window:** only a write in the same cycle as the accept is forwarded. Writes at T-1 are already in the RAM; writes at T+1 or later are ignored.

## Test plan
- **Basic read:** preload addr 0x10=0xA5..A5, rsp_ready=1, request 0x10 at cycle 5 → ram_rd_en at 5, rsp_valid at 7 with rsp_data=0xA5..A5, a single cycle.
- **Collision:** RAM[0x20]=0x11..1; at cycle 5 wr_en=1, wr_addr=0x20, wr_data=0x22..2 and read 0x20 → rsp_data=0x22..2. A repeat with wr_addr=0x21 → 0x11..1.
- **Late write:** read 0x30 (old 0x33..3) at T, write 0x30=0x44..4 at T+1 → response 0x33..3. A read at T+2 → 0x44..4.
- **Backpressure:**
  - rsp_ready=0, continuous requests to 0x00..0x05 → exactly 3 accepted (0x00–0x02), then rd_req_ready=0 and ram_rd_en=0.
  - Raise rsp_ready → responses appear in order 0x00, 0x01, 0x02, and requests resume.
- **Streaming:** 64 back-to-back requests to consecutive addresses, some collisions, rsp_ready=1 → rd_req_ready never drops, 64 responses, matching the reference model in order.
- **Reset mid-op:**
  - With 2 buffered responses and 1 in flight, pulse rst_n low for 1 cycle → rsp_valid=0 immediately and rsp_data=0.
  - After release no stale responses appear; rd_req_ready=1 and a new read returns correct data at +2.

Source files
------------

// File: rtl/ram_rd_bypass.sv
// Read-side front end for a 1R1W read-first SRAM: issues reads, forwards same-cycle
// write collisions, and returns responses in order through a 3-entry credit-managed buffer.
module ram_rd_bypass #(
    parameter int RAM_DATA_WIDTH = 272,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DEPTH      = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [RAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [RAM_DATA_WIDTH-1:0] wr_data,
    input  logic                      rd_req_valid,
    output logic                      rd_req_ready,
    input  logic [RAM_ADDR_WIDTH-1:0] rd_addr,
    output logic                      ram_rd_en,
    output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [RAM_DATA_WIDTH-1:0] ram_rd_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [RAM_DATA_WIDTH-1:0] rsp_data
);

    localparam int FIFO_DEPTH = 3;

    logic [1:0]                fifo_count;
    logic [1:0]                wr_ptr;
    logic [1:0]                rd_ptr;
    logic                      inflight;
    logic                      byp_hit;
    logic [RAM_DATA_WIDTH-1:0] byp_data;
    logic [RAM_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic [2:0]                credit_used;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic [RAM_DATA_WIDTH-1:0] push_data;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A response still in the RAM pipeline already owns a buffer slot; pops free credit next cycle.
    assign credit_used  = {1'b0, fifo_count} + {2'b00, inflight};
    assign rd_req_ready = rst_n && (credit_used < 3'd3);
    assign accept       = rd_req_valid && rd_req_ready;
    assign ram_rd_en    = accept;
    assign ram_rd_addr  = rd_addr;

    assign push      = inflight;
    assign push_data = byp_hit ? byp_data : ram_rd_data;
    assign rsp_valid = (fifo_count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count <= 2'd0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            inflight   <= 1'b0;
            byp_hit    <= 1'b0;
            byp_data   <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                byp_hit <= wr_en && (wr_addr == rd_addr);
                if (wr_en && (wr_addr == rd_addr))
                    byp_data <= wr_data;
            end else begin
                byp_hit <= 1'b0;
            end
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)
                fifo_count <= fifo_count + 2'd1;
            else if (pop && !push)
                fifo_count <= fifo_count - 2'd1;
        end
    end

    // NOTE: storage is reset explicitly so rsp_data reads as zero during and after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_mem[i] <= '0;
        end else if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fifo_count == 2'd3));

    addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (32'(rd_addr) < RAM_DEPTH));

endmodule

// File: tb/tb_ram_rd_bypass.sv
// Directed bench for ram_rd_bypass: behavioural read-first RAM plus an in-order
// scoreboard fed on each accepted request and drained on each response handshake.
module tb_ram_rd_bypass;

    localparam int DW = 272;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_addr;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_cnt  = 0;
    logic [DW-1:0] sb [$];

    logic [DW-1:0] ram [256];
    logic          preload_done = 1'b0;

    ram_rd_bypass #(.RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .RAM_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        logic [7:0] b;
        b = 8'(a) ^ 8'hC3;
        case (a)
            'h10:    return {34{8'hA5}};
            'h20:    return {34{8'h11}};
            'h30:    return {34{8'h33}};
            default: return {34{b}};
        endcase
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [287:0] t;
        for (int k = 0; k < 9; k++)
            t[k*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    // Read-first synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (!preload_done) begin
            for (int i = 0; i < 256; i++)
                ram[i] <= init_word(i);
            preload_done <= 1'b1;
        end else begin
            if (ram_rd_en)
                ram_rd_data <= ram[ram_rd_addr];
            if (wr_en)
                ram[wr_addr] <= wr_data;
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected value fixed at accept time (write data wins on a same-cycle hit).
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            if (rd_req_valid && rd_req_ready) begin
                check("ram_rd_en_on_accept", ram_rd_en, 1);
                sb.push_back((wr_en && wr_addr == rd_addr) ? wr_data : ram[rd_addr]);
            end
            if (prev_hold && rsp_valid)
                check("rsp_data_hold", rsp_data, prev_data);
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                if (sb.size() == 0)
                    check("unexpected_rsp", rsp_valid, 0);
                else
                    check("rsp_order_data", rsp_data, sb.pop_front());
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst_n = 1'b1;
        wr_en = 0; wr_addr = '0; wr_data = '0;
        rd_req_valid = 0; rd_addr = '0; rsp_ready = 0;
        #1 rst_n = 1'b0;

        // Reset state, with a request presented while in reset
        repeat (3) tick();
        rd_req_valid = 1; rd_addr = 8'h10;
        #2;
        check("rst_rd_req_ready", rd_req_ready, 0);
        check("rst_ram_rd_en", ram_rd_en, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        rd_req_valid = 0;
        tick();
        rst_n = 1'b1;
        #2;
        check("release_ready", rd_req_ready, 1);
        check("release_rsp_valid", rsp_valid, 0);

        // Basic read: two-cycle latency, single-cycle response
        rsp_ready = 1;
        tick();
        rd_req_valid = 1; rd_addr = 8'h10;
        #2;
        check("basic_rd_en", ram_rd_en, 1);
        check("basic_rd_addr", ram_rd_addr, 8'h10);
        tick();
        rd_req_valid = 0;
        #2 check("basic_t1_invalid", rsp_valid, 0);
        tick();
        #2;
        check("basic_t2_valid", rsp_valid, 1);
        check("basic_data", rsp_data, {34{8'hA5}});
        tick();
        #2 check("basic_single_cycle", rsp_valid, 0);

        // Write to a different address in the same cycle: no forwarding
        tick();
        rd_req_valid = 1; rd_addr = 8'h20;
        wr_en = 1; wr_addr = 8'h21; wr_data = {34{8'h55}};
        tick();
        rd_req_valid = 0; wr_en = 0;
        tick();
        #2 check("nohit_data", rsp_data, {34{8'h11}});

        // Same-cycle write to the read address: write data forwarded
        tick();
        rd_req_valid = 1; rd_addr = 8'h20;
        wr_en = 1; wr_addr = 8'h20; wr_data = {34{8'h22}};
        tick();
        rd_req_valid = 0; wr_en = 0;
        tick();
        #2 check("collision_data", rsp_data, {34{8'h22}});

        // Write one cycle after the read is ignored; a later read sees it
        tick();
        rd_req_valid = 1; rd_addr = 8'h30;
        tick();
        rd_req_valid = 0;
        wr_en = 1; wr_addr = 8'h30; wr_data = {34{8'h44}};
        tick();
        wr_en = 0;
        rd_req_valid = 1; rd_addr = 8'h30;
        #2 check("late_write_old", rsp_data, {34{8'h33}});
        tick();
        rd_req_valid = 0;
        tick();
        #2 check("late_write_new", rsp_data, {34{8'h44}});

        // Backpressure: only three requests accepted with the consumer stalled
        tick();
        rsp_ready = 0;
        repeat (2) tick();
        for (int i = 0; i < 6; i++) begin
            rd_req_valid = 1; rd_addr = 8'(i);
            #2;
            check($sformatf("bp_ready_%0d", i), rd_req_ready, (i < 3) ? 1 : 0);
            check($sformatf("bp_rd_en_%0d", i), ram_rd_en, (i < 3) ? 1 : 0);
            tick();
        end
        rd_req_valid = 0;
        #2;
        check("bp_full_valid", rsp_valid, 1);
        check("bp_head_data", rsp_data, {34{8'hC3}});
        check("bp_full_ready", rd_req_ready, 0);
        rsp_ready = 1;
        tick();
        #2 check("bp_ready_after_pop", rd_req_ready, 1);
        rd_req_valid = 1; rd_addr = 8'h06;
        tick();
        rd_req_valid = 0;
        repeat (6) tick();
        check("bp_drained", 32'(sb.size()), 0);

        // Streaming: 64 back-to-back reads with interleaved collisions
        base = rsp_cnt;
        for (int i = 0; i < 64; i++) begin
            rd_req_valid = 1; rd_addr = 8'(8'h40 + i);
            if (i % 5 == 2) begin
                wr_en = 1; wr_addr = rd_addr; wr_data = rand_word();
            end else if (i % 3 == 0) begin
                wr_en = 1; wr_addr = rd_addr + 8'd1; wr_data = rand_word();
            end else begin
                wr_en = 0;
            end
            #2 check($sformatf("stream_ready_%0d", i), rd_req_ready, 1);
            tick();
        end
        rd_req_valid = 0; wr_en = 0;
        repeat (6) tick();
        check("stream_rsp_count", 32'(rsp_cnt - base), 64);
        check("stream_drained", 32'(sb.size()), 0);

        // Reset with two buffered responses and one in flight
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            rd_req_valid = 1; rd_addr = 8'(8'h50 + i);
            tick();
        end
        rd_req_valid = 0;
        #2 check("pre_reset_valid", rsp_valid, 1);
        rst_n = 0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_data", rsp_data, 0);
        check("midrst_ready", rd_req_ready, 0);
        tick();
        rst_n = 1;
        #2;
        check("postrst_ready", rd_req_ready, 1);
        check("postrst_valid", rsp_valid, 0);
        rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #2 check($sformatf("postrst_no_stale_%0d", i), rsp_valid, 0);
        end
        tick();
        rd_req_valid = 1; rd_addr = 8'h10;
        tick();
        rd_req_valid = 0;
        tick();
        #2;
        check("postrst_read_valid", rsp_valid, 1);
        check("postrst_read_data", rsp_data, {34{8'hA5}});
        repeat (4) tick();
        check("final_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
